// File: rtl/dff_sweep_pkg.sv
// Shared constants, lane-parameter bit positions, FSM/phase enums and LFSR helpers
// for the DFF sweep checker.
package dff_sweep_pkg;

    localparam int NUM_LANES = 64;
    localparam int LANE_W    = 6;
    localparam int PERIOD_W  = 16;
    localparam int ERR_W     = 8;
    localparam int LFSR_W    = 16;

    // Bit positions inside i = lane >> 1
    localparam int P_CLK_INV = 0;
    localparam int P_EN_INV  = 1;
    localparam int P_SR_INV  = 2;
    localparam int P_SR_VAL  = 3;
    localparam int P_INIT    = 4;

    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Right-shift Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK0 = 2'd1,
        ST_RUN    = 2'd2,
        ST_FIN    = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PH_P0 = 2'd0,
        PH_P1 = 2'd1,
        PH_P2 = 2'd2,
        PH_P3 = 2'd3
    } phase_t;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
        return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
    endfunction

    function automatic logic [LANE_W-1:0] lowest_set(input logic [NUM_LANES-1:0] v);
        logic [LANE_W-1:0] idx;
        idx = '0;
        for (int k = NUM_LANES - 1; k >= 0; k--) begin
            if (v[k]) idx = LANE_W'(k);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dff_sweep_checker_lane.sv
// Reference model of one flop in the sweep array; its flavour (clock/enable
// polarity, set/reset behaviour, initial value) is fixed by the lane index.
module dff_lane_model
    import dff_sweep_pkg::*;
#(
    parameter int LANE = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic rise,
    input  logic fall,
    input  logic d,
    input  logic en,
    output logic expected
);

    localparam logic [4:0] I         = 5'(LANE >> 1);
    localparam logic       J         = 1'(LANE & 1);
    localparam logic       SR_ACTIVE = J ^ I[P_SR_INV];
    localparam logic       RST_VAL   = SR_ACTIVE ? I[P_SR_VAL] : I[P_INIT];

    logic edge_hit;

    assign edge_hit = I[P_CLK_INV] ? fall : rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected <= RST_VAL;
        end else if (SR_ACTIVE) begin
            expected <= I[P_SR_VAL];
        end else if (edge_hit && (en ^ I[P_EN_INV])) begin
            expected <= d;
        end
    end

endmodule

// File: rtl/dff_sweep_checker.sv
// Drives a 64-lane DFF sweep array with LFSR stimulus over a four-phase dut_clk
// and compares its outputs against per-lane reference models once per period.
//
// state  | meaning
// IDLE   | waiting for start; status outputs hold results of the last run
// CHECK0 | one compare of q against the model before any dut_clk edge
// RUN    | four-phase dut_clk periods; compare at P0 of each completed period
// FIN    | one-cycle done pulse carrying pass
module dff_sweep_checker
    import dff_sweep_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [PERIOD_W-1:0]  num_periods,
    input  logic [NUM_LANES-1:0] q,
    output logic                 dut_clk,
    output logic                 d,
    output logic                 en,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_W-1:0]     err_count,
    output logic [LANE_W-1:0]    first_fail_lane,
    output logic [NUM_LANES-1:0] fail_mask
);

    state_t               state, state_nxt;
    phase_t               phase, phase_nxt;
    logic                 first_p0;
    logic [PERIOD_W-1:0]  period_cnt;
    logic [LFSR_W-1:0]    lfsr, lfsr_adv;
    logic                 launch, do_compare, advance;
    logic                 enter_p1, enter_p3;
    logic                 d_nxt, en_nxt;
    logic [NUM_LANES-1:0] expected, mismatch, mask_nxt;
    logic [ERR_W-1:0]     err_nxt;
    logic [LANE_W-1:0]    ffl_nxt;

    always_comb begin
        state_nxt  = state;
        phase_nxt  = phase;
        launch     = 1'b0;
        do_compare = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = ST_CHECK0;
                end
            end
            ST_CHECK0: begin
                do_compare = 1'b1;
                state_nxt  = ST_RUN;
                phase_nxt  = PH_P0;
            end
            ST_RUN: begin
                unique case (phase)
                    PH_P0: begin
                        // The P0 right after CHECK0 has no completed period behind it
                        if (!first_p0) do_compare = 1'b1;
                        if (!first_p0 && period_cnt == PERIOD_W'(1)) state_nxt = ST_FIN;
                        else phase_nxt = PH_P1;
                    end
                    PH_P1: phase_nxt = PH_P2;
                    PH_P2: phase_nxt = PH_P3;
                    PH_P3: phase_nxt = PH_P0;
                    default: phase_nxt = PH_P0;
                endcase
            end
            ST_FIN: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign advance  = do_compare && (state == ST_RUN);
    assign enter_p1 = (state == ST_RUN) && (phase == PH_P0) && (phase_nxt == PH_P1);
    assign enter_p3 = (state == ST_RUN) && (phase == PH_P2);
    assign lfsr_adv = advance ? lfsr_step(lfsr) : lfsr;
    // New stimulus is taken from the already-advanced LFSR so each period gets a fresh pattern
    assign d_nxt    = enter_p1 ? lfsr_adv[0] : d;
    assign en_nxt   = enter_p1 ? lfsr_adv[1] : en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            phase      <= PH_P0;
            first_p0   <= 1'b0;
            period_cnt <= '0;
            lfsr       <= LFSR_SEED;
            dut_clk    <= 1'b0;
            d          <= 1'b0;
            en         <= 1'b0;
        end else begin
            state   <= state_nxt;
            phase   <= phase_nxt;
            dut_clk <= (state_nxt == ST_RUN) && ((phase_nxt == PH_P1) || (phase_nxt == PH_P2));
            d       <= d_nxt;
            en      <= en_nxt;
            if (launch) begin
                lfsr       <= LFSR_SEED;
                period_cnt <= (num_periods == '0) ? PERIOD_W'(1) : num_periods;
            end else begin
                lfsr <= lfsr_adv;
                if (advance && period_cnt != PERIOD_W'(1)) period_cnt <= period_cnt - 1'b1;
            end
            if (state == ST_CHECK0) first_p0 <= 1'b1;
            else if (enter_p1) first_p0 <= 1'b0;
        end
    end

    always_comb begin
        mismatch = q ^ expected;
        err_nxt  = err_count;
        mask_nxt = fail_mask;
        ffl_nxt  = first_fail_lane;
        if (launch) begin
            err_nxt  = '0;
            mask_nxt = '0;
            ffl_nxt  = '0;
        end else if (do_compare && (|mismatch)) begin
            if (err_count != '1) err_nxt = err_count + 1'b1;
            mask_nxt = fail_mask | mismatch;
            if (err_count == '0) ffl_nxt = lowest_set(mismatch);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_lane <= '0;
            fail_mask       <= '0;
        end else begin
            err_count       <= err_nxt;
            first_fail_lane <= ffl_nxt;
            fail_mask       <= mask_nxt;
            done            <= (state_nxt == ST_FIN);
            if (launch) begin
                busy <= 1'b1;
                pass <= 1'b0;
            end else if (state_nxt == ST_FIN) begin
                busy <= 1'b0;
                pass <= (err_nxt == '0);
            end
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        dff_lane_model #(.LANE(g)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .rise     (enter_p1),
            .fall     (enter_p3),
            .d        (d_nxt),
            .en       (en_nxt),
            .expected (expected[g])
        );
    end

endmodule

// File: tb/tb_dff_sweep_checker.sv
// Self-checking bench: a behavioural 64-flop array reacts to dut_clk/d/en, faults
// are overlaid on q, and expected run results are scoreboarded per start.
module tb_dff_sweep_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] num_periods = '0;
    logic [63:0] q;
    logic [63:0] inv_mask = '0;
    logic [63:0] stuck0_mask = '0;
    logic [63:0] arr;
    logic        prev_clk;
    logic        dut_clk, d, en, busy, done, pass;
    logic [7:0]  err_count;
    logic [5:0]  first_fail_lane;
    logic [63:0] fail_mask;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          np;
        logic [63:0] inv;
        logic [63:0] stuck0;
        logic        exp_pass;
        int          exp_err;
        int          exp_ffl;
        logic [63:0] exp_mask;
    } vec_t;

    typedef struct {
        logic        pass;
        int          err;
        int          ffl;
        logic [63:0] mask;
        int          cycles;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];

    always #5 clk = ~clk;

    dff_sweep_checker dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .num_periods     (num_periods),
        .q               (q),
        .dut_clk         (dut_clk),
        .d               (d),
        .en              (en),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_fail_lane (first_fail_lane),
        .fail_mask       (fail_mask)
    );

    assign q = (arr ^ inv_mask) & ~stuck0_mask;

    function automatic bit lane_bit(int l, int pos);
        return bit'(((l >> 1) >> pos) & 1);
    endfunction

    function automatic bit sr_active(int l);
        return bit'(l & 1) ^ lane_bit(l, 2);
    endfunction

    function automatic logic [15:0] ref_lfsr_next(logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    // Ideal flop array, sampled mid-cycle when dut_clk/d/en are stable
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int l = 0; l < 64; l++) arr[l] <= sr_active(l) ? lane_bit(l, 3) : lane_bit(l, 4);
            prev_clk <= 1'b0;
        end else begin
            for (int l = 0; l < 64; l++) begin
                if (sr_active(l)) arr[l] <= lane_bit(l, 3);
                else if ((lane_bit(l, 0) ? (prev_clk && !dut_clk) : (!prev_clk && dut_clk))
                         && (en ^ lane_bit(l, 1))) arr[l] <= d;
            end
            prev_clk <= dut_clk;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input string tag, input vec_t v, input int stray_at);
        exp_t        e, got;
        int          cyc, rises, np_eff;
        logic [15:0] ref_lfsr;
        logic        prev;
        inv_mask    = v.inv;
        stuck0_mask = v.stuck0;
        np_eff      = (v.np == 0) ? 1 : v.np;
        e.pass      = v.exp_pass;
        e.err       = v.exp_err;
        e.ffl       = v.exp_ffl;
        e.mask      = v.exp_mask;
        e.cycles    = 4 * np_eff + 3;
        sb.push_back(e);
        ref_lfsr    = 16'hACE1;
        rises       = 0;
        prev        = 1'b0;
        cyc         = 0;
        num_periods = 16'(v.np);
        start       = 1'b1;
        do begin
            tick();
            cyc++;
            start = (cyc == stray_at);
            if (start) num_periods = 16'd50;
            if (dut_clk && !prev) begin
                if (rises < 6) begin
                    check($sformatf("%s d period %0d", tag, rises), d, ref_lfsr[0]);
                    check($sformatf("%s en period %0d", tag, rises), en, ref_lfsr[1]);
                end
                ref_lfsr = ref_lfsr_next(ref_lfsr);
                rises++;
            end
            prev = dut_clk;
        end while (!done && cyc < 5000);
        start = 1'b0;
        got = sb.pop_front();
        check({tag, " done seen"}, done, 1'b1);
        check({tag, " cycles"}, cyc, got.cycles);
        check({tag, " pass"}, pass, got.pass);
        check({tag, " err_count"}, err_count, got.err);
        check({tag, " first_fail_lane"}, first_fail_lane, got.ffl);
        check({tag, " fail_mask"}, fail_mask, got.mask);
        check({tag, " busy at done"}, busy, 1'b0);
        check({tag, " dut_clk at done"}, dut_clk, 1'b0);
        tick();
        check({tag, " done one cycle"}, done, 1'b0);
        check({tag, " err_count held"}, err_count, got.err);
        check({tag, " busy after"}, busy, 1'b0);
    endtask

    initial begin
        logic saw_done;
        vecs[0] = '{100, 64'h0,                 64'h0,                 1'b1, 0,   0,  64'h0};
        vecs[1] = '{100, 64'h20,                64'h0,                 1'b0, 101, 5,  64'h20};
        vecs[2] = '{10,  64'h0,                 64'h0000_0100_0000_0000, 1'b1, 0, 0,  64'h0};
        vecs[3] = '{10,  64'h0,                 64'h0000_0000_0002_0000, 1'b0, 11, 17, 64'h0000_0000_0002_0000};
        vecs[4] = '{300, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,               1'b0, 255, 0,  64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{0,   64'h0,                 64'h0,                 1'b1, 0,   0,  64'h0};
        vecs[6] = '{1,   64'h8000_0000_0000_0000, 64'h0,               1'b0, 2,   63, 64'h8000_0000_0000_0000};
        vecs[7] = '{5,   64'h208,               64'h0,                 1'b0, 6,   3,  64'h208};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset pass", pass, 1'b0);
        check("reset err_count", err_count, 8'd0);
        check("reset first_fail_lane", first_fail_lane, 6'd0);
        check("reset fail_mask", fail_mask, 64'h0);
        check("reset dut_clk", dut_clk, 1'b0);
        check("reset d", d, 1'b0);
        check("reset en", en, 1'b0);
        rst_n = 1'b1;
        repeat (2) tick();

        for (int k = 0; k < 8; k++) begin
            run_vec($sformatf("vec%0d", k), vecs[k], 0);
            repeat (2) tick();
        end

        // start pulsed while busy must not relaunch or retarget the run
        run_vec("stray_start", '{3, 64'h0, 64'h0, 1'b1, 0, 0, 64'h0}, 4);
        repeat (3) tick();
        check("stray_start no relaunch", busy, 1'b0);

        // Abort in P2 with an asynchronous reset
        inv_mask    = '0;
        stuck0_mask = '0;
        num_periods = 16'd20;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("abort in P2 dut_clk high", dut_clk, 1'b1);
        check("abort in P2 busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("abort dut_clk low", dut_clk, 1'b0);
        check("abort busy low", busy, 1'b0);
        check("abort d", d, 1'b0);
        check("abort en", en, 1'b0);
        tick();
        rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (8) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        check("abort no done", saw_done, 1'b0);
        run_vec("post_abort", '{4, 64'h0, 64'h0, 1'b1, 0, 0, 64'h0}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
